// File: rtl/debug_terminal.sv
// debug_terminal: snapshots CHANNELS status words and prints them as one hex ASCII line
// (flags, then each word MSB-nibble first, CR-terminated) to the AVR link. Lines are sent
// periodically on tmr or on demand. Single-character terminal commands control the flags.
module debug_terminal #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tmr_i,
  input  logic [CHANNELS*WIDTH-1:0] ch_data_i,
  input  logic [7:0]                rx_data_i,
  input  logic                      new_rx_data_i,
  input  logic                      tx_busy_i,
  output logic [7:0]                tx_data_o,
  output logic                      new_tx_data_o,
  output logic                      arm_o,
  output logic                      log_o,
  output logic                      reset_req_o,
  output logic [7:0]                overrun_cnt_o
);

  localparam int unsigned Digits  = WIDTH / 4;
  localparam int unsigned LineLen = 3 + CHANNELS * (1 + Digits) + 1;
  localparam int unsigned IdxW    = $clog2(LineLen);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LineLen - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                    state_q;
  logic [IdxW-1:0]           idx_q;
  logic [CHANNELS*WIDTH-1:0] snap_data_q;
  logic                      snap_arm_q;
  logic                      snap_log_q;
  logic                      arm_q;
  logic                      log_q;
  logic                      paused_q;
  logic                      pending_q;
  logic                      reset_req_q;
  logic [7:0]                overrun_q;

  logic       cmd_m, cmd_d, cmd_p, cmd_s, cmd_r;
  logic       accept, send_char, overrun_hit;
  logic [7:0] char_d;
  logic [3:0] nib;
  logic       is_digit;

  // Command decode and FSM handshake conditions.
  always_comb begin
    cmd_m       = new_rx_data_i && (rx_data_i == 8'h6d);
    cmd_d       = new_rx_data_i && (rx_data_i == 8'h64);
    cmd_p       = new_rx_data_i && (rx_data_i == 8'h70);
    cmd_s       = new_rx_data_i && (rx_data_i == 8'h73);
    cmd_r       = new_rx_data_i && (rx_data_i == 8'h72);
    accept      = (state_q == StIdle) && ((tmr_i && !paused_q) || pending_q);
    send_char   = (state_q == StSend) && !tx_busy_i;
    overrun_hit = (state_q == StSend) && tmr_i && !paused_q;
  end

  // Output FSM: take the snapshot on acceptance, then walk the line one char per free cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      snap_data_q <= '0;
      snap_arm_q  <= 1'b0;
      snap_log_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            snap_data_q <= ch_data_i;
            snap_arm_q  <= arm_q;
            snap_log_q  <= log_q;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (send_char) begin
            if (idx_q == LastIdx) begin
              state_q <= StIdle;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Terminal command state and overrun counter; runs independently of the output FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q       <= 1'b0;
      log_q       <= 1'b0;
      paused_q    <= 1'b0;
      pending_q   <= 1'b0;
      reset_req_q <= 1'b0;
      overrun_q   <= 8'd0;
    end else begin
      if (cmd_m) arm_q <= ~arm_q;
      if (cmd_d) log_q <= ~log_q;
      if (cmd_p) paused_q <= ~paused_q;
      // A request landing in the acceptance cycle must survive to give a second line.
      if (cmd_s) pending_q <= 1'b1;
      else if (accept) pending_q <= 1'b0;
      reset_req_q <= cmd_r;
      // Clear wins over a simultaneous dropped trigger.
      if (cmd_r) overrun_q <= 8'd0;
      else if (overrun_hit && (overrun_q != 8'hff)) overrun_q <= overrun_q + 8'd1;
    end
  end

  // Character for the current index, built only from the snapshot.
  always_comb begin
    char_d   = 8'h20;
    nib      = 4'h0;
    is_digit = 1'b0;
    if (idx_q == '0) begin
      char_d = snap_arm_q ? 8'h41 : 8'h44;
    end else if (idx_q == IdxW'(2)) begin
      char_d = snap_log_q ? 8'h52 : 8'h49;
    end else if (idx_q == LastIdx) begin
      char_d = 8'h0d;
    end
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned k = 0; k < Digits; k++) begin
        if (32'(idx_q) == 4 + c * (Digits + 1) + k) begin
          is_digit = 1'b1;
          nib      = snap_data_q[c*WIDTH + (Digits-1-k)*4 +: 4];
        end
      end
    end
    if (is_digit) begin
      char_d = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end
  end

  assign tx_data_o     = char_d;
  assign new_tx_data_o = send_char;
  assign arm_o         = arm_q;
  assign log_o         = log_q;
  assign reset_req_o   = reset_req_q;
  assign overrun_cnt_o = overrun_q;

endmodule

// File: doc/debug_terminal.md
# debug_terminal

Parametrised successor to the single-line avionics debug printer. It snapshots CHANNELS status words and prints them as one hex ASCII line to the AVR USB link, either periodically on `tmr` or on demand. It parses single-character terminal commands for arm, log, pause, single-shot and reset-request, and counts dropped periodic triggers. It sits between the avionics status sources and the AVR serial interface.

## Interface
- CHANNELS, default 4: number of status words printed per line (1..8).
- WIDTH, default 16: bits per status word; must be a multiple of 4 (4..32).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tmr  in  1  periodic print strobe, one cycle wide.
- ch_data  in  CHANNELS*WIDTH  status words; channel i is bits [i*WIDTH +: WIDTH].
- rx_data  in  8  received terminal byte.
- new_rx_data  in  1  rx_data valid, one cycle wide.
- tx_busy  in  1  AVR transmitter busy.
- tx_data  out  8  character to transmit.
- new_tx_data  out  1  tx_data valid strobe.
- arm  out  1  motor arm flag.
- log  out  1  datalog enable flag.
- reset_req  out  1  one-cycle board reset request.
- overrun_cnt  out  8  saturating count of dropped `tmr` triggers.

## Operation
- Line length L = 3 + CHANNELS*(1 + WIDTH/4) + 1. With the defaults, L = 24.
- Line layout:
  - char 0: 'A' if armed, else 'D'.
  - char 1: ' '.
  - char 2: 'R' if log is set, else 'I'.
  - Then, for channel 0 up to channel CHANNELS-1: ' ' followed by WIDTH/4 hex digits, most-significant nibble first, using uppercase '0'-'9' and 'A'-'F'.
  - Last char: "\r".
- Snapshot: on trigger acceptance, ch_data, arm and log are registered. The whole line is built from the snapshot, so later input or flag changes never affect an in-flight line.
- Output FSM has two states, IDLE and SEND.
  - IDLE: char index = 0. The block accepts a trigger if (tmr AND NOT paused) OR pending. On acceptance it takes the snapshot, clears pending and moves to SEND.
  - SEND: in each cycle with tx_busy = 0, new_tx_data = 1 and tx_data = char[index], and the index increments. When the index equals L-1 in such a cycle, the FSM returns to IDLE.
  - While tx_busy = 1, new_tx_data = 0 and the index holds.
- Overrun: tmr = 1 while in SEND and not paused increments overrun_cnt, saturating at 255. That trigger is dropped.
- Commands are acted on in the cycle new_rx_data = 1 and take effect on the next edge. They are lowercase only; every other byte is ignored.
  - 'm': toggle arm.
  - 'd': toggle log.
  - 'p': toggle paused.
  - 's': set pending. A one-deep request; it is served at the next IDLE and held while in SEND.
  - 'r': pulse reset_req for one cycle and clear overrun_cnt.
- Command parsing is independent of the output FSM and runs concurrently with SEND.

## Timing
- Reset values: state IDLE, index 0, arm 0, log 0, paused 0, pending 0, overrun_cnt 0, reset_req 0, new_tx_data 0. The snapshot is zero, so tx_data = 'D'.
- Reset mid-line aborts immediately; no new_tx_data is issued on the cycle after rst.
- tmr at cycle n while in IDLE: snapshot at edge n, SEND from n+1, earliest first new_tx_data at n+1.
- With tx_busy held at 0, the line occupies exactly L consecutive cycles, followed by at least one IDLE cycle.
- tx_busy handshake: new_tx_data is a one-cycle strobe. The upstream interface asserts tx_busy from the cycle after an accepted character. tx_data is stable whenever new_tx_data = 1.
- Command at cycle n: arm, log and paused change at n+1; reset_req is high only in cycle n+1.
- Simultaneous events:
  - tmr in the final SEND cycle counts as an overrun.
  - tmr and pending together in IDLE start one line and clear pending.
  - 's' arriving in the acceptance cycle sets pending, producing a second line.
  - 'r' coinciding with an overrun increment: the clear wins.
- overrun_cnt does not wrap past 255.

## Test plan
- Reset, then tmr with ch_data = {16'hBEEF, 16'h0012, 16'hA5A5, 16'h0000} and tx_busy = 0 -> 24 strobes in consecutive cycles spelling "D I 0000 A5A5 0012 BEEF\r".
- Send 'm', then 'd', then tmr -> line begins "A R"; arm = 1 and log = 1 one cycle after each byte.
- Change ch_data and send 'm' during SEND -> the in-flight line is unchanged; the next line shows the new values.
- Send 'p' (paused), pulse tmr 5 times -> no output and overrun_cnt = 0; then send 's' -> exactly one line.
- Hold tx_busy high for 3 cycles after each strobe and pulse tmr at 300 points mid-line -> every char is emitted once and in order, and overrun_cnt saturates at 255; then send 'r' -> reset_req high for 1 cycle and overrun_cnt = 0.
- Assert rst at index 10 -> new_tx_data = 0 from the next cycle; all outputs return to their reset values; the next tmr restarts the line at char 0.
